fifo_sync_flags: RTL

- Parametrised single-clock FIFO. Successor to the basic synchronous FIFO.
- Adds two read modes: standard registered read, or first-word-fall-through (FWFT).
- Adds programmable almost-full/almost-empty thresholds, an occupancy count output, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between producer and consumer blocks in the same clock domain as the general-purpose buffer.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_dpram.sv | 39 +++
 rtl/fifo_sync_flags.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the synchronous FIFO with flags.
//   - fifo_mode_e : read mode selector (registered read or first-word-fall-through)
//   - fifo_depth  : number of words addressed by a given address width
//   - fifo_mode   : maps the integer FWFT parameter onto fifo_mode_e
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Any non-zero FWFT value selects fall-through mode; the top level
  // separately rejects values other than 0 and 1.
  function automatic fifo_mode_e fifo_mode(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// fifo_dpram
//   Simple dual-port RAM, DATA_WIDTH x 2**ADDR_WIDTH, used as FIFO storage.
//   Ports:
//     clk_i    : clock, write port is synchronous to its rising edge
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address
//     rdata_o  : read data, asynchronous (combinational) from raddr_i
//   Contents are not reset.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read is left combinational so the top level can either register it
  // (standard mode) or present it directly (fall-through mode).
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
//   Single-clock FIFO with selectable read mode, programmable almost-full /
//   almost-empty thresholds, occupancy count, sticky error flags and a
//   synchronous flush.
//   Ports:
//     clk          : clock, all state updates on the rising edge
//     rst          : synchronous active-high reset
//     wr_en        : write request, accepted when not full
//     data_in      : write data
//     rd_en        : read request (pop in fall-through mode), accepted when not empty
//     flush        : synchronous clear of contents, overrides wr_en/rd_en
//     clr_err      : clears overflow/underflow (a simultaneous set wins)
//     data_out     : read data
//     FIFO_full    : count == DEPTH
//     FIFO_empty   : count == 0
//     almost_full  : count >= AF_THRESH
//     almost_empty : count <= AE_THRESH
//     count        : occupancy 0..DEPTH
//     overflow     : sticky, a write was rejected because the FIFO was full
//     underflow    : sticky, a read was rejected because the FIFO was empty
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  FIFO_full,
  output logic                  FIFO_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int         DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int         PW    = ADDR_WIDTH + 1;
  localparam fifo_mode_e MODE  = fifo_mode(FWFT);

  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] AF_W    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_W    = PW'(AE_THRESH);

  // Elaboration-time parameter checks
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_THRESH=%0d outside legal range 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_THRESH=%0d outside legal range 0..%0d", AE_THRESH, DEPTH - 1);
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_sync_flags: FWFT=%0d must be 0 or 1", FWFT);
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // with identical low address bits.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [PW-1:0]         cnt;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Modulo subtraction gives the occupancy directly, including across wrap.
  assign cnt   = wptr_q - rptr_q;
  assign full  = (cnt == DEPTH_W);
  assign empty = (cnt == '0);

  // Acceptance looks only at the registered state, so a read at full does
  // not make room for a same-cycle write, and vice versa at empty.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
    end
  end

  // Sticky errors: the set term is applied after the clear so a coincident
  // set wins. Requests dropped by flush are not treated as errors.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && full && !flush)  ovf_d = 1'b1;
    if (rd_en && empty && !flush) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dpram (
    .clk_i   (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (data_in),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (flush) begin
        dout_d = '0;
      end else if (rd_acc) begin
        dout_d = rdata;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is shown as soon as it is written; zero while empty so the
    // output never exposes stale RAM contents.
    assign data_out = empty ? '0 : rdata;
  end

  assign FIFO_full    = full;
  assign FIFO_empty   = empty;
  assign almost_full  = (cnt >= AF_W);
  assign almost_empty = (cnt <= AE_W);
  assign count        = cnt;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
